// File: rtl/spirose_pkg.sv
// Shared types and timing constants for the rotor front end and column_mux.
// Slice periods below MIN_SLICE_CYCLES cannot fit a full column drive sweep.
package spirose_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      RUN     = 2'd2
   } rot_state_t;

   localparam int unsigned COLUMN_DRIVE_CYCLES = 331;
   localparam int unsigned N_COLUMNS           = 8;
   localparam int unsigned MIN_SLICE_CYCLES    = COLUMN_DRIVE_CYCLES * N_COLUMNS;

endpackage

// File: rtl/hall_debouncer.sv
// Hall sensor conditioning: 2-FF synchronizer, stability filter, falling-edge pulse.
// Latency: rev_evt 2 + DEBOUNCE_CYCLES cycles after a hall_n fall (+/-1 sync phase).
// No backpressure: rev_evt is a free-running one-cycle pulse.
module hall_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 64
) (
   input  logic clk_33,
   input  logic nrst,
   input  logic hall_n,
   output logic rev_evt
);

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rev_q, rev_d;

   // Counter only runs while the synchronized input disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      rev_d = level_q & ~level_d;
   end

   always_ff @(posedge clk_33 or negedge nrst) begin
      if (!nrst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         rev_q   <= 1'b0;
      end else begin
         sync1_q <= hall_n;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rev_q   <= rev_d;
      end
   end

   assign rev_evt = rev_q;

endmodule

// File: rtl/rotation_slice_timer.sv
// Splits each rotor revolution into N_SLICES evenly spaced framebuffer_sync pulses.
// Latency: first sync one cycle after the accepting rev_evt; outputs registered.
// No backpressure: pulses free-run; overspeed or stall suppresses them.
module rotation_slice_timer #(
   parameter int unsigned N_SLICES         = 128,
   parameter int unsigned PERIOD_BITS      = 24,
   parameter int unsigned DEBOUNCE_CYCLES  = 64,
   parameter int unsigned MIN_SLICE_CYCLES = spirose_pkg::MIN_SLICE_CYCLES
) (
   input  logic                        clk_33,
   input  logic                        nrst,
   input  logic                        hall_n,
   output logic                        framebuffer_sync,
   output logic [$clog2(N_SLICES)-1:0] slice_idx,
   output logic                        running,
   output logic                        overspeed,
   output logic [PERIOD_BITS-1:0]      period
);

   import spirose_pkg::*;

   localparam int unsigned SB = $clog2(N_SLICES);
   localparam int unsigned TB = PERIOD_BITS - SB;
   localparam logic [SB-1:0] IDX_LAST = SB'(N_SLICES - 1);

   logic                   rev_evt;
   logic                   rev_sat;
   logic                   meas_ok;
   logic [PERIOD_BITS-1:0] meas;
   logic [TB-1:0]          slice_per;

   rot_state_t             state_q, state_d;
   logic [PERIOD_BITS-1:0] rev_cnt_q, rev_cnt_d;
   logic [PERIOD_BITS-1:0] period_q, period_d;
   logic [TB-1:0]          tmr_q, tmr_d;
   logic [SB-1:0]          idx_q, idx_d;
   logic                   sync_q, sync_d;
   logic                   ovs_q, ovs_d;

   hall_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_hall_debouncer (
      .clk_33 (clk_33),
      .nrst   (nrst),
      .hall_n (hall_n),
      .rev_evt(rev_evt)
   );

   assign rev_sat   = &rev_cnt_q;
   assign meas      = rev_cnt_q + PERIOD_BITS'(1);
   assign slice_per = meas[PERIOD_BITS-1:SB];
   assign meas_ok   = 32'(slice_per) >= MIN_SLICE_CYCLES;

   always_comb begin
      rev_cnt_d = rev_evt ? '0 : (rev_sat ? rev_cnt_q : rev_cnt_q + PERIOD_BITS'(1));
      state_d   = state_q;
      period_d  = period_q;
      tmr_d     = tmr_q;
      idx_d     = idx_q;
      sync_d    = 1'b0;
      ovs_d     = ovs_q;
      case (state_q)
         IDLE: begin
            // No valid reference edge yet, so this event only starts a measurement.
            if (rev_evt) state_d = ACQUIRE;
         end
         ACQUIRE, RUN: begin
            if (rev_sat) begin
               state_d = IDLE;
               idx_d   = '0;
               tmr_d   = '0;
            end else if (rev_evt) begin
               idx_d = '0;
               if (meas_ok) begin
                  state_d  = RUN;
                  ovs_d    = 1'b0;
                  period_d = meas;
                  sync_d   = 1'b1;
                  tmr_d    = slice_per - TB'(1);
               end else begin
                  state_d = ACQUIRE;
                  ovs_d   = 1'b1;
                  tmr_d   = '0;
               end
            end else if (state_q == RUN) begin
               if (tmr_q != '0) begin
                  tmr_d = tmr_q - TB'(1);
               end else if (idx_q != IDX_LAST) begin
                  sync_d = 1'b1;
                  idx_d  = idx_q + SB'(1);
                  tmr_d  = period_q[PERIOD_BITS-1:SB] - TB'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_33 or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         rev_cnt_q <= '0;
         period_q  <= '0;
         tmr_q     <= '0;
         idx_q     <= '0;
         sync_q    <= 1'b0;
         ovs_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rev_cnt_q <= rev_cnt_d;
         period_q  <= period_d;
         tmr_q     <= tmr_d;
         idx_q     <= idx_d;
         sync_q    <= sync_d;
         ovs_q     <= ovs_d;
      end
   end

   assign framebuffer_sync = sync_q;
   assign slice_idx        = idx_q;
   assign running          = (state_q == RUN);
   assign overspeed        = ovs_q;
   assign period           = period_q;

endmodule
